vga_text_writer: RTL
====================

// Module: vga_text_writer
// PURPOSE
//  Console writer for the VGA text buffer (COLS x ROWS ASCII cells, addr = row*COLS + col).
//  Accepts one character per valid/ready handshake from the CPU/keyboard path and maintains a cursor.
//  Writes glyphs into the text RAM and handles CR, LF, BS and FF.
//  Scrolls the buffer up one row when output runs off the last row.
//  Drives the write/read port of the text RAM that the VGA scan-out side does not use.
// PARAMETERS
//  COLS    70  characters per row
//  ROWS    30  rows per screen
//  ADDR_W  12  text RAM address width; COLS*ROWS <= 2**ADDR_W
//  BLANK   8'h20  fill code used for clears and backspace
// PORTS
//  sys_clk      in   1       system clock; all logic on rising edge
//  rst_n        in   1       synchronous active-low reset
//  char_valid   in   1       char_data valid
//  char_data    in   8       ASCII code to emit
//  char_ready   out  1       high only in IDLE; transfer when char_valid & char_ready
//  ram_wren     out  1       text RAM write strobe, one cycle per cell
//  ram_wraddr   out  ADDR_W  text RAM write address
//  ram_wrdata   out  8       text RAM write data
//  ram_rdaddr   out  ADDR_W  text RAM read address (scroll copy)
//  ram_rddata   in   8       text RAM read data, valid 1 sys_clk after ram_rdaddr
//  cursor_addr  out  ADDR_W  row*COLS+col of cursor (for cursor overlay)
//  busy         out  1       ~char_ready
// BEHAVIOUR
//  Reset (rst_n=0 at edge): state<=CLEAR, col=row=0, ram_wren=0, ram_wraddr=0, ram_rdaddr=0,
//   char_ready=0. A reset mid-scroll or mid-clear aborts it immediately; the clear restarts from cell 0.
//  States: CLEAR, IDLE, PUT, SCROLL, SCROLL_CLR.
//  CLEAR: ram_wren=1, ram_wrdata=BLANK, address 0..COLS*ROWS-1, one cell per cycle; then col=row=0 and -> IDLE.
//  IDLE: char_ready=1. On a handshake, char_data is decoded in the same cycle:
//   8'h0D CR: col<=0; stay in IDLE. No RAM write.
//   8'h0A LF: col<=0. If row<ROWS-1, row<=row+1; else -> SCROLL.
//   8'h0C FF: -> CLEAR.
//   8'h08 BS:
//    - col>0: col<=col-1.
//    - col==0 & row>0: row<=row-1, col<=COLS-1.
//    - Then -> PUT, which writes BLANK at the new cursor without advancing.
//    - At (0,0): no-op, stay in IDLE.
//   Other codes 8'h00-8'h1F: consumed and dropped, stay in IDLE.
//   8'h20-8'hFF: latch the code, -> PUT.
//  PUT: one cycle with ram_wren=1, ram_wraddr=cursor_addr, ram_wrdata=latched code.
//   - For BS: -> IDLE, cursor unchanged.
//   - Otherwise col<=col+1. At col==COLS-1, col<=0 and row+1.
//   - At row==ROWS-1, the wrap goes -> SCROLL; otherwise -> IDLE.
//   Throughput: 1 printable char per 2 cycles.
//  SCROLL: pipelined copy of source cells COLS..COLS*ROWS-1.
//   - Cycle k issues ram_rdaddr=s. Cycle k+1 writes ram_rddata to s-COLS.
//   - Each read overlaps the previous write.
//   - Duration: COLS*(ROWS-1)+1 cycles. -> SCROLL_CLR.
//  SCROLL_CLR: writes BLANK to (ROWS-1)*COLS..COLS*ROWS-1, one per cycle.
//   Then cursor = (col 0, row ROWS-1) and -> IDLE.
//  Cursor invariants: col<=COLS-1 and row<=ROWS-1 always; cursor_addr = row*COLS+col, computed combinationally.
//  Address arithmetic:
//   - Computed at ADDR_W bits and never exceeds COLS*ROWS-1.
//   - Row/col counters are wide enough for COLS-1 and ROWS-1.
//  Data-path rules:
//   - char_valid while busy: the char is held by the source; none is lost or duplicated.
//   - ram_wren is never high in IDLE.
// TESTING
//  1. Release reset: 2100 writes of 8'h20 to addr 0..2099, then char_ready=1 and cursor_addr=0.
//  2. Send 'A','B': write (0,8'h41) then (1,8'h42). cursor_addr=2. char_ready low 1 cycle after each char.
//  3. Send 70 x 'x' from (0,0): last write at addr 69, cursor_addr=70.
//     Then CR: cursor_addr stays 70. Then BS: write 8'h20 at 69, cursor_addr=69.
//  4. Preload row r with code 8'h30+r. Cursor at (69,29), send 'Z':
//     - write 'Z' at 2099
//     - RAM addr 0..2029 = old addr 70..2099, including 'Z' now at 2029
//     - 2030..2099 = 8'h20
//     - cursor_addr=2030
//  5. LF at row 29 triggers the same scroll, ending with cursor_addr=2030.
//     FF mid-screen: full clear, cursor_addr=0. BS at (0,0): no write, cursor_addr=0.
//  6. Drop rst_n midway through a scroll: next cycle ram_wren=0. After release, a full clear from addr 0.
//     Hold char_valid throughout: exactly one accept, only after the clear ends.

Source files
------------

// File: rtl/vga_text_writer.sv
// Console writer for the VGA text buffer: glyph writes, CR/LF/BS/FF handling,
// full-screen clear and one-row scroll through the spare text RAM port.
module vga_text_writer #(
    parameter int          COLS   = 70,
    parameter int          ROWS   = 30,
    parameter int          ADDR_W = 12,
    parameter logic [7:0]  BLANK  = 8'h20
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              char_valid,
    input  logic [7:0]        char_data,
    output logic              char_ready,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_wraddr,
    output logic [7:0]        ram_wrdata,
    output logic [ADDR_W-1:0] ram_rdaddr,
    input  logic [7:0]        ram_rddata,
    output logic [ADDR_W-1:0] cursor_addr,
    output logic              busy
);
    localparam int CELLS = COLS * ROWS;
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam int CNT_W = ADDR_W + 1;

    localparam logic [ADDR_W-1:0] A_COLS = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] A_LROW = ADDR_W'((ROWS - 1) * COLS);
    localparam logic [COL_W-1:0]  C_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  R_LAST = ROW_W'(ROWS - 1);
    localparam logic [CNT_W-1:0]  N_CELL = CNT_W'(CELLS);

    typedef enum logic [2:0] {CLEAR, IDLE, PUT, SCROLL, SCROLL_CLR} state_t;

    state_t            state, state_n;
    logic [COL_W-1:0]  col, col_n;
    logic [ROW_W-1:0]  row, row_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              wren_q, wren_n;
    logic [ADDR_W-1:0] wraddr_q, wraddr_n;
    logic [7:0]        wrdata_q, wrdata_n;
    logic [ADDR_W-1:0] rdaddr_q, rdaddr_n;
    logic              copy_q, copy_n;
    logic              bs_q, bs_n;

    assign cursor_addr = ADDR_W'(row) * A_COLS + ADDR_W'(col);
    assign char_ready  = (state == IDLE);
    assign busy        = ~char_ready;
    assign ram_wren    = wren_q;
    assign ram_wraddr  = wraddr_q;
    assign ram_rdaddr  = rdaddr_q;
    // During the scroll copy the read data goes straight to the write port.
    assign ram_wrdata  = copy_q ? ram_rddata : wrdata_q;

    // Write-port signals are registered: each state's write is scheduled on entry.
    always_comb begin
        state_n  = state;
        col_n    = col;
        row_n    = row;
        cnt_n    = cnt;
        wren_n   = 1'b0;
        wraddr_n = wraddr_q;
        wrdata_n = wrdata_q;
        rdaddr_n = rdaddr_q;
        copy_n   = 1'b0;
        bs_n     = bs_q;
        unique case (state)
            CLEAR: begin
                if (!wren_q) begin
                    wren_n   = 1'b1;
                    wraddr_n = '0;
                    wrdata_n = BLANK;
                end else if (wraddr_q != A_LAST) begin
                    wren_n   = 1'b1;
                    wraddr_n = wraddr_q + ADDR_W'(1);
                end else begin
                    state_n = IDLE;
                    col_n   = '0;
                    row_n   = '0;
                end
            end
            IDLE: begin
                if (char_valid) begin
                    case (char_data)
                        8'h0D: col_n = '0;
                        8'h0A: begin
                            col_n = '0;
                            if (row != R_LAST) begin
                                row_n = row + ROW_W'(1);
                            end else begin
                                state_n  = SCROLL;
                                rdaddr_n = A_COLS;
                                cnt_n    = CNT_W'(COLS + 1);
                            end
                        end
                        8'h0C: state_n = CLEAR;
                        8'h08: begin
                            if (col != '0 || row != '0) begin
                                if (col != '0) begin
                                    col_n = col - COL_W'(1);
                                end else begin
                                    row_n = row - ROW_W'(1);
                                    col_n = C_LAST;
                                end
                                // The new cursor is always the cell just before the old one.
                                state_n  = PUT;
                                wren_n   = 1'b1;
                                wraddr_n = cursor_addr - ADDR_W'(1);
                                wrdata_n = BLANK;
                                bs_n     = 1'b1;
                            end
                        end
                        default: begin
                            if (char_data >= 8'h20) begin
                                state_n  = PUT;
                                wren_n   = 1'b1;
                                wraddr_n = cursor_addr;
                                wrdata_n = char_data;
                                bs_n     = 1'b0;
                            end
                        end
                    endcase
                end
            end
            PUT: begin
                state_n = IDLE;
                if (!bs_q) begin
                    if (col == C_LAST) begin
                        col_n = '0;
                        if (row == R_LAST) begin
                            state_n  = SCROLL;
                            rdaddr_n = A_COLS;
                            cnt_n    = CNT_W'(COLS + 1);
                        end else begin
                            row_n = row + ROW_W'(1);
                        end
                    end else begin
                        col_n = col + COL_W'(1);
                    end
                end
            end
            SCROLL: begin
                // cnt is the next source to read; past the end only the last write drains.
                if (cnt <= N_CELL) begin
                    wren_n   = 1'b1;
                    copy_n   = 1'b1;
                    wraddr_n = rdaddr_q - A_COLS;
                    cnt_n    = cnt + CNT_W'(1);
                    if (cnt < N_CELL) rdaddr_n = cnt[ADDR_W-1:0];
                end else begin
                    state_n  = SCROLL_CLR;
                    wren_n   = 1'b1;
                    wraddr_n = A_LROW;
                    wrdata_n = BLANK;
                end
            end
            SCROLL_CLR: begin
                if (wraddr_q != A_LAST) begin
                    wren_n   = 1'b1;
                    wraddr_n = wraddr_q + ADDR_W'(1);
                end else begin
                    state_n = IDLE;
                    col_n   = '0;
                    row_n   = R_LAST;
                end
            end
            default: state_n = CLEAR;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            state    <= CLEAR;
            col      <= '0;
            row      <= '0;
            cnt      <= '0;
            wren_q   <= 1'b0;
            wraddr_q <= '0;
            wrdata_q <= BLANK;
            rdaddr_q <= '0;
            copy_q   <= 1'b0;
            bs_q     <= 1'b0;
        end else begin
            state    <= state_n;
            col      <= col_n;
            row      <= row_n;
            cnt      <= cnt_n;
            wren_q   <= wren_n;
            wraddr_q <= wraddr_n;
            wrdata_q <= wrdata_n;
            rdaddr_q <= rdaddr_n;
            copy_q   <= copy_n;
            bs_q     <= bs_n;
        end
    end
endmodule
